rvfi_insn_window_check: RTL and testbench
=========================================

# rvfi_insn_window_check

Sequential, parametrised RVFI retirement checker for simulation and bounded model checking. It compares up to NRET retirements per cycle against per-channel spec-model results, which come from externally instantiated insn models. It also enforces contiguous `rvfi_order` and PC chaining across channels and across cycles, over a window of WINDOW retirements. Results are latched into sticky, registered status outputs for a testbench or a formal wrapper. It sits beside the per-insn checks in `checks/`.

## Interface
Parameters:
- NRET, 2: retirement channels.
- XLEN, 32: register/PC width.
- WINDOW, 16: retirements to check before DONE (1..65535).
- CHECK_PC_CHAIN, 1: enable cross-retirement PC continuity check.

Ports:
- clock  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  pulse; arms checking.
- start_order  in  64  order expected for the first checked retirement.
- rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr  in  NRET each  per-channel flags.
- rvfi_order  in  64*NRET
- rvfi_rd_addr  in  5*NRET
- rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata  in  XLEN*NRET each
- rvfi_mem_wmask  in  (XLEN/8)*NRET
- spec_valid, spec_trap  in  NRET each  spec-model results per channel.
- spec_rd_addr  in  5*NRET
- spec_rd_wdata, spec_pc_wdata  in  XLEN*NRET each
- busy  out  1  state RUN.
- done  out  1  state DONE (sticky).
- fail  out  1  state FAIL (sticky).
- fail_code  out  3  first failure cause.
- fail_chan  out  $clog2(NRET) (min 1)  channel of first failure.
- fail_order  out  64  rvfi_order of the failing retirement.
- retired  out  $clog2(WINDOW+1)  retirements checked so far.

## Operation
- States: IDLE, RUN, DONE, FAIL.
- IDLE -> RUN on `start`: exp_order <= start_order; retired <= 0; pc_known <= 0.
- RUN -> FAIL on any error; RUN -> DONE when retired+popcount >= WINDOW or any valid channel has rvfi_halt.
- DONE and FAIL are terminal until reset. `start` is ignored outside IDLE; rvfi inputs are ignored outside RUN.
- Per-cycle packing rule: valid channels must be a prefix (channel i valid implies channels 0..i-1 valid). Violation -> ORDER error on the first hole.
- Per valid channel i, with k = number of valid channels below i, the checks below are evaluated and the first true one wins:
  - ORDER (1): rvfi_order != exp_order+k.
  - PC_CHAIN (2): CHECK_PC_CHAIN, !rvfi_intr[i], predecessor known, and rvfi_pc_rdata != predecessor pc_wdata. The predecessor is channel i-1 if valid, else the last_pc register.
  - SPEC_INVALID (3): !spec_valid.
  - TRAP (4): spec_trap != rvfi_trap.
  - TRAP_SIDE (5): trap and (rd_addr != 0, rd_wdata != 0, or mem_wmask != 0).
  - RD (6): !trap and (rd_addr or rd_wdata differs from spec).
  - PC_NEXT (7): !trap and pc_wdata != spec_pc_wdata.
- The lowest failing channel determines fail_code, fail_chan and fail_order.
- On a clean RUN cycle with n valid channels: exp_order += n; retired += n, saturating at WINDOW; last_pc <= pc_wdata of the highest valid channel; pc_known <= 1 if n > 0.
- Order arithmetic is modulo 2^64. Wrap is legal.
- Same-cycle conflicts: error and halt -> FAIL. Error and window complete -> FAIL.

## Timing
- All outputs are registered. Status reflects retirements presented in cycle t at clock edge t+1.
- start -> busy = 1 after 1 edge. The first retirement can be checked in the cycle after start.
- Reset values: busy, done, fail = 0; fail_code, fail_chan, fail_order, retired = 0; state IDLE.
- Asserting resetn low mid-RUN forces the reset values immediately (asynchronously). Release is sampled on the next edge.
- No backpressure: every valid retirement in RUN must be consumed the same cycle.

## Structure
- Package rvfi_check_pkg holds:
  - state enum;
  - fail_code enum (NONE = 0 … PC_NEXT = 7);
  - ORDER_W = 64.
- Sub-module rvfi_channel_cmp: combinational per-channel comparator producing a 3-bit code. It is instantiated NRET times in a generate loop. The top keeps the FSM, exp_order, last_pc and counters.

## Test plan
- Single clean run: NRET=2, WINDOW=4, start_order=10. Orders 10,11 then 12,13, with pc chain 0x100->0x104->0x108->0x10C and spec matching -> done=1, retired=4, fail=0.
- Gap: orders 10 then 12 -> fail=1, fail_code=1, fail_order=12, fail_chan=0.
- PC break: channel 0 pc_wdata=0x104, channel 1 pc_rdata=0x200, intr=0 -> fail_code=2, fail_chan=1. The same stimulus with rvfi_intr[1]=1 passes.
- Trap side effect: spec_trap=1, rvfi_trap=1, rd_addr=5 -> fail_code=5.
- Wrap and conflicts: start_order=2^64-1, two retirements with orders 2^64-1 and 0 -> passes. Halt and an RD error in the same cycle -> FAIL with fail_code=6.
- Reset mid-run: resetn low after 2 retirements -> all outputs 0 without waiting for a clock edge. A new start then runs from a fresh start_order.

Source files
------------

// File: rtl/rvfi_insn_window_check_pkg.sv
// Purpose: shared types for the RVFI retirement window checker (FSM states, failure codes).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rvfi_check_pkg;

    localparam int ORDER_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    // Numeric values are visible on fail_code; keep them stable.
    typedef enum logic [2:0] {
        FC_NONE         = 3'd0,
        FC_ORDER        = 3'd1,
        FC_PC_CHAIN     = 3'd2,
        FC_SPEC_INVALID = 3'd3,
        FC_TRAP         = 3'd4,
        FC_TRAP_SIDE    = 3'd5,
        FC_RD           = 3'd6,
        FC_PC_NEXT      = 3'd7
    } fail_code_t;

endpackage

// File: rtl/rvfi_insn_window_check_if.sv
// Purpose: bundles the per-channel RVFI retirement fields and the matching spec-model results.
// Latency: n/a (wires only).
// Backpressure: none; the master presents retirements, the slave consumes every valid one each cycle.
// Ports: rvfi_* = core retirement trace, spec_* = reference model results, channel i in slice i.
interface rvfi_insn_window_check_if
    import rvfi_check_pkg::*;
#(
    parameter int NRET = 2,
    parameter int XLEN = 32
);
    logic [NRET-1:0]            rvfi_valid;
    logic [NRET-1:0]            rvfi_trap;
    logic [NRET-1:0]            rvfi_halt;
    logic [NRET-1:0]            rvfi_intr;
    logic [ORDER_W*NRET-1:0]    rvfi_order;
    logic [5*NRET-1:0]          rvfi_rd_addr;
    logic [XLEN*NRET-1:0]       rvfi_rd_wdata;
    logic [XLEN*NRET-1:0]       rvfi_pc_rdata;
    logic [XLEN*NRET-1:0]       rvfi_pc_wdata;
    logic [(XLEN/8)*NRET-1:0]   rvfi_mem_wmask;
    logic [NRET-1:0]            spec_valid;
    logic [NRET-1:0]            spec_trap;
    logic [5*NRET-1:0]          spec_rd_addr;
    logic [XLEN*NRET-1:0]       spec_rd_wdata;
    logic [XLEN*NRET-1:0]       spec_pc_wdata;

    modport master (
        output rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_order, rvfi_rd_addr,
               rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_wmask,
               spec_valid, spec_trap, spec_rd_addr, spec_rd_wdata, spec_pc_wdata
    );

    modport slave (
        input  rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_order, rvfi_rd_addr,
               rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_wmask,
               spec_valid, spec_trap, spec_rd_addr, spec_rd_wdata, spec_pc_wdata
    );
endinterface

// File: rtl/rvfi_insn_window_check_cmp.sv
// Purpose: single-channel retirement comparator; returns the highest-priority failure code.
// Latency: combinational.
// Backpressure: none.
// Ports: channel fields in, expected order / predecessor pc from the top, 3-bit code out (0 = clean).
module rvfi_channel_cmp
    import rvfi_check_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                 valid,
    input  logic                 hole,          // a lower channel is invalid while this one is valid
    input  logic [ORDER_W-1:0]   exp_order,
    input  logic [ORDER_W-1:0]   order,
    input  logic                 pc_chk,        // chain check enabled and predecessor pc known
    input  logic [XLEN-1:0]      pred_pc,
    input  logic                 intr,
    input  logic                 trap,
    input  logic [4:0]           rd_addr,
    input  logic [XLEN-1:0]      rd_wdata,
    input  logic [XLEN-1:0]      pc_rdata,
    input  logic [XLEN-1:0]      pc_wdata,
    input  logic [XLEN/8-1:0]    mem_wmask,
    input  logic                 spec_valid,
    input  logic                 spec_trap,
    input  logic [4:0]           spec_rd_addr,
    input  logic [XLEN-1:0]      spec_rd_wdata,
    input  logic [XLEN-1:0]      spec_pc_wdata,
    output fail_code_t           code
);
    // Priority chain: the first failing check names the cause.
    always_comb begin
        code = FC_NONE;
        if (valid) begin
            if (hole || (order != exp_order))
                code = FC_ORDER;
            else if (pc_chk && !intr && (pc_rdata != pred_pc))
                code = FC_PC_CHAIN;
            else if (!spec_valid)
                code = FC_SPEC_INVALID;
            else if (spec_trap != trap)
                code = FC_TRAP;
            else if (trap && ((rd_addr != 5'd0) || (rd_wdata != '0) || (mem_wmask != '0)))
                code = FC_TRAP_SIDE;
            else if (!trap && ((rd_addr != spec_rd_addr) || (rd_wdata != spec_rd_wdata)))
                code = FC_RD;
            else if (!trap && (pc_wdata != spec_pc_wdata))
                code = FC_PC_NEXT;
        end
    end
endmodule

// File: rtl/rvfi_insn_window_check.sv
// Purpose: checks NRET retirements/cycle for order contiguity, pc chaining and spec agreement over WINDOW retirements.
// Latency: retirements in cycle t are reflected on the registered status at edge t+1.
// Backpressure: none; every valid retirement in RUN is consumed in the cycle it is presented.
// Ports: clock/resetn, start+start_order arm the run, rvfi (slave bundle), sticky busy/done/fail status and fail details.
module rvfi_insn_window_check
    import rvfi_check_pkg::*;
#(
    parameter int NRET           = 2,
    parameter int XLEN           = 32,
    parameter int WINDOW         = 16,
    parameter int CHECK_PC_CHAIN = 1,
    localparam int CHAN_W        = (NRET > 1) ? $clog2(NRET) : 1,
    localparam int RET_W         = $clog2(WINDOW + 1)
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [ORDER_W-1:0]   start_order,
    rvfi_insn_window_check_if.slave rvfi,
    output logic                 busy,
    output logic                 done,
    output logic                 fail,
    output logic [2:0]           fail_code,
    output logic [CHAN_W-1:0]    fail_chan,
    output logic [ORDER_W-1:0]   fail_order,
    output logic [RET_W-1:0]     retired
);
    localparam int CNT_W = $clog2(NRET + 1);

    state_t               state, state_nxt;
    logic [ORDER_W-1:0]   exp_order;
    logic [XLEN-1:0]      last_pc;
    logic                 pc_known;

    logic [NRET-1:0]      hole;
    logic [NRET-1:0]      pred_known;
    logic [ORDER_W-1:0]   ch_exp  [NRET];
    logic [XLEN-1:0]      pred_pc [NRET];
    fail_code_t           ch_code [NRET];
    logic [CNT_W-1:0]     n_vld;
    logic [XLEN-1:0]      hi_pc;
    logic                 seen_gap;
    logic                 prev_vld;
    logic [XLEN-1:0]      prev_pc;

    // Per-channel expected order, hole detection and pc predecessor.
    // Walking upward, a channel's predecessor is the previous channel when
    // that one retired, otherwise the pc carried over from earlier cycles.
    always_comb begin
        n_vld    = '0;
        hi_pc    = last_pc;
        seen_gap = 1'b0;
        prev_vld = 1'b0;
        prev_pc  = last_pc;
        for (int i = 0; i < NRET; i++) begin
            ch_exp[i]     = exp_order + ORDER_W'(n_vld);
            hole[i]       = seen_gap;
            pred_pc[i]    = prev_vld ? prev_pc : last_pc;
            pred_known[i] = (CHECK_PC_CHAIN != 0) && (prev_vld || pc_known);
            prev_vld      = rvfi.rvfi_valid[i];
            prev_pc       = rvfi.rvfi_pc_wdata[i*XLEN +: XLEN];
            if (rvfi.rvfi_valid[i]) begin
                n_vld = n_vld + CNT_W'(1);
                hi_pc = rvfi.rvfi_pc_wdata[i*XLEN +: XLEN];
            end else begin
                seen_gap = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NRET; g++) begin : g_ch
        rvfi_channel_cmp #(.XLEN(XLEN)) u_cmp (
            .valid         (rvfi.rvfi_valid[g]),
            .hole          (hole[g]),
            .exp_order     (ch_exp[g]),
            .order         (rvfi.rvfi_order[g*ORDER_W +: ORDER_W]),
            .pc_chk        (pred_known[g]),
            .pred_pc       (pred_pc[g]),
            .intr          (rvfi.rvfi_intr[g]),
            .trap          (rvfi.rvfi_trap[g]),
            .rd_addr       (rvfi.rvfi_rd_addr[g*5 +: 5]),
            .rd_wdata      (rvfi.rvfi_rd_wdata[g*XLEN +: XLEN]),
            .pc_rdata      (rvfi.rvfi_pc_rdata[g*XLEN +: XLEN]),
            .pc_wdata      (rvfi.rvfi_pc_wdata[g*XLEN +: XLEN]),
            .mem_wmask     (rvfi.rvfi_mem_wmask[g*(XLEN/8) +: (XLEN/8)]),
            .spec_valid    (rvfi.spec_valid[g]),
            .spec_trap     (rvfi.spec_trap[g]),
            .spec_rd_addr  (rvfi.spec_rd_addr[g*5 +: 5]),
            .spec_rd_wdata (rvfi.spec_rd_wdata[g*XLEN +: XLEN]),
            .spec_pc_wdata (rvfi.spec_pc_wdata[g*XLEN +: XLEN]),
            .code          (ch_code[g])
        );
    end

    // Lowest failing channel wins; also derive halt and window completion.
    logic                 err;
    fail_code_t           f_code;
    logic [CHAN_W-1:0]    f_chan;
    logic [ORDER_W-1:0]   f_order;
    logic                 halt;
    logic [31:0]          win_sum;
    logic                 win_full;

    always_comb begin
        err     = 1'b0;
        f_code  = FC_NONE;
        f_chan  = '0;
        f_order = '0;
        for (int i = 0; i < NRET; i++) begin
            if (!err && (ch_code[i] != FC_NONE)) begin
                err     = 1'b1;
                f_code  = ch_code[i];
                f_chan  = CHAN_W'(i);
                f_order = rvfi.rvfi_order[i*ORDER_W +: ORDER_W];
            end
        end
        halt     = |(rvfi.rvfi_valid & rvfi.rvfi_halt);
        win_sum  = 32'(retired) + 32'(n_vld);
        win_full = (win_sum >= 32'(WINDOW));
    end

    // Errors take precedence over halt and window completion in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (err)                   state_nxt = ST_FAIL;
                else if (win_full || halt) state_nxt = ST_DONE;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_code  <= 3'd0;
            fail_chan  <= '0;
            fail_order <= '0;
            retired    <= '0;
            exp_order  <= '0;
            last_pc    <= '0;
            pc_known   <= 1'b0;
        end else begin
            busy <= (state_nxt == ST_RUN);
            done <= (state_nxt == ST_DONE);
            fail <= (state_nxt == ST_FAIL);
            if (state == ST_IDLE && start) begin
                exp_order <= start_order;
                retired   <= '0;
                pc_known  <= 1'b0;
            end else if (state == ST_RUN) begin
                if (err) begin
                    fail_code  <= f_code;
                    fail_chan  <= f_chan;
                    fail_order <= f_order;
                end else begin
                    exp_order <= exp_order + ORDER_W'(n_vld);
                    retired   <= win_full ? RET_W'(WINDOW) : RET_W'(win_sum);
                    if (n_vld != '0) begin
                        last_pc  <= hi_pc;
                        pc_known <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rvfi_insn_window_check.sv
module tb_rvfi_insn_window_check;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [63:0] start_order = '0;
    logic        busy, done, fail;
    logic [2:0]  fail_code;
    logic        fail_chan;
    logic [63:0] fail_order;
    logic [2:0]  retired;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    rvfi_insn_window_check_if #(.NRET(2), .XLEN(32)) rv ();

    rvfi_insn_window_check #(.NRET(2), .XLEN(32), .WINDOW(4), .CHECK_PC_CHAIN(1)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .start_order (start_order),
        .rvfi        (rv),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .fail_code   (fail_code),
        .fail_chan   (fail_chan),
        .fail_order  (fail_order),
        .retired     (retired)
    );

    // One retirement cycle: ch0/ch1 stimulus plus the status expected after the edge.
    // pc_wdata is always pc_rdata+4; spec mirrors rvfi unless a *bad mask corrupts it.
    typedef struct {
        logic        nw;
        logic [63:0] so;
        logic [1:0]  vld;
        logic [63:0] o0, o1;
        logic [31:0] p0, p1;
        logic [1:0]  intr, halt, trap, strap;
        logic [4:0]  rd0;
        logic [1:0]  rdbad, svbad, pcnbad;
        logic        e_done, e_fail;
        logic [2:0]  e_code;
        logic        e_chan;
        logic [63:0] e_ord;
        logic [2:0]  e_ret;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic nw, input logic [63:0] so, input logic [1:0] vld,
        input logic [63:0] o0, input logic [63:0] o1, input logic [31:0] p0, input logic [31:0] p1,
        input logic [1:0] intr, input logic [1:0] halt, input logic [1:0] trap, input logic [1:0] strap,
        input logic [4:0] rd0, input logic [1:0] rdbad, input logic [1:0] svbad, input logic [1:0] pcnbad,
        input logic e_done, input logic e_fail, input logic [2:0] e_code, input logic e_chan,
        input logic [63:0] e_ord, input logic [2:0] e_ret);
        vec_t r;
        r.nw = nw; r.so = so; r.vld = vld; r.o0 = o0; r.o1 = o1; r.p0 = p0; r.p1 = p1;
        r.intr = intr; r.halt = halt; r.trap = trap; r.strap = strap; r.rd0 = rd0;
        r.rdbad = rdbad; r.svbad = svbad; r.pcnbad = pcnbad;
        r.e_done = e_done; r.e_fail = e_fail; r.e_code = e_code; r.e_chan = e_chan;
        r.e_ord = e_ord; r.e_ret = e_ret;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic e_busy, input logic e_done,
                                input logic e_fail, input logic [2:0] e_code, input logic e_chan,
                                input logic [63:0] e_ord, input logic [2:0] e_ret);
        chk({tag, ".busy"},       64'(busy),       64'(e_busy));
        chk({tag, ".done"},       64'(done),       64'(e_done));
        chk({tag, ".fail"},       64'(fail),       64'(e_fail));
        chk({tag, ".fail_code"},  64'(fail_code),  64'(e_code));
        chk({tag, ".fail_chan"},  64'(fail_chan),  64'(e_chan));
        chk({tag, ".fail_order"}, fail_order,      e_ord);
        chk({tag, ".retired"},    64'(retired),    64'(e_ret));
    endtask

    task automatic clear_inputs();
        rv.rvfi_valid = '0; rv.rvfi_trap = '0; rv.rvfi_halt = '0; rv.rvfi_intr = '0;
        rv.rvfi_order = '0; rv.rvfi_rd_addr = '0; rv.rvfi_rd_wdata = '0;
        rv.rvfi_pc_rdata = '0; rv.rvfi_pc_wdata = '0; rv.rvfi_mem_wmask = '0;
        rv.spec_valid = '0; rv.spec_trap = '0; rv.spec_rd_addr = '0;
        rv.spec_rd_wdata = '0; rv.spec_pc_wdata = '0;
    endtask

    task automatic drive(input vec_t v);
        rv.rvfi_valid     = v.vld;
        rv.rvfi_trap      = v.trap;
        rv.rvfi_halt      = v.halt;
        rv.rvfi_intr      = v.intr;
        rv.rvfi_order     = {v.o1, v.o0};
        rv.rvfi_rd_addr   = {5'd0, v.rd0};
        rv.rvfi_rd_wdata  = '0;
        rv.rvfi_pc_rdata  = {v.p1, v.p0};
        rv.rvfi_pc_wdata  = {v.p1 + 32'd4, v.p0 + 32'd4};
        rv.rvfi_mem_wmask = '0;
        rv.spec_valid     = ~v.svbad;
        rv.spec_trap      = v.strap;
        rv.spec_rd_addr   = {5'd0, v.rd0};
        rv.spec_rd_wdata  = {31'd0, v.rdbad[1], 31'd0, v.rdbad[0]};
        rv.spec_pc_wdata  = {(v.p1 + 32'd4) ^ (v.pcnbad[1] ? 32'd4 : 32'd0),
                             (v.p0 + 32'd4) ^ (v.pcnbad[0] ? 32'd4 : 32'd0)};
    endtask

    task automatic do_reset();
        @(negedge clock);
        clear_inputs();
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic do_start(input logic [63:0] so);
        @(negedge clock);
        clear_inputs();
        start       = 1'b1;
        start_order = so;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clock);
        drive(v);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        //             nw so                     vld    o0                     o1  p0     p1     intr   halt   trap   strap  rd0 rdbad  svbad  pcnbad dn fl code ch ord ret
        // clean window of 4: 2+2, then inputs after DONE are ignored
        tbl.push_back(mk(1, 10,                    2'b11, 10,                    11, 'h100, 'h104, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0,  2));
        tbl.push_back(mk(0, 0,                     2'b11, 12,                    13, 'h108, 'h10C, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0,  4));
        tbl.push_back(mk(0, 0,                     2'b11, 99,                    7,  'h000, 'h000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0,  4));
        // order gap across cycles
        tbl.push_back(mk(1, 10,                    2'b01, 10,                    0,  'h100, 'h000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0,  1));
        tbl.push_back(mk(0, 0,                     2'b01, 12,                    0,  'h104, 'h000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 1, 0, 12, 1));
        // pc break on ch1, then the same with an interrupt on ch1
        tbl.push_back(mk(1, 10,                    2'b11, 10,                    11, 'h100, 'h200, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 2, 1, 11, 0));
        tbl.push_back(mk(1, 10,                    2'b11, 10,                    11, 'h100, 'h200, 2'b10, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0,  2));
        // trap with rd write side effect
        tbl.push_back(mk(1, 10,                    2'b01, 10,                    0,  'h100, 'h000, 2'b00, 2'b00, 2'b01, 2'b01, 5, 2'b00, 2'b00, 2'b00, 0, 1, 5, 0, 10, 0));
        // spec invalid, trap mismatch, pc_next mismatch
        tbl.push_back(mk(1, 10,                    2'b01, 10,                    0,  'h100, 'h000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b01, 2'b00, 0, 1, 3, 0, 10, 0));
        tbl.push_back(mk(1, 10,                    2'b11, 10,                    11, 'h100, 'h104, 2'b00, 2'b00, 2'b00, 2'b10, 0, 2'b00, 2'b00, 2'b00, 0, 1, 4, 1, 11, 0));
        tbl.push_back(mk(1, 10,                    2'b11, 10,                    11, 'h100, 'h104, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b10, 0, 1, 7, 1, 11, 0));
        // packing hole: ch1 valid without ch0
        tbl.push_back(mk(1, 10,                    2'b10, 0,                     10, 'h000, 'h100, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 1, 1, 10, 0));
        // order wrap at 2^64
        tbl.push_back(mk(1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 0,  'h100, 'h104, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0,  2));
        tbl.push_back(mk(0, 0,                     2'b11, 1,                     2,  'h108, 'h10C, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0,  4));
        // halt and RD error in the same cycle, then halt alone
        tbl.push_back(mk(1, 10,                    2'b11, 10,                    11, 'h100, 'h104, 2'b00, 2'b10, 2'b00, 2'b00, 0, 2'b10, 2'b00, 2'b00, 0, 1, 6, 1, 11, 0));
        tbl.push_back(mk(1, 10,                    2'b01, 10,                    0,  'h100, 'h000, 2'b00, 2'b01, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0,  1));
        // retired saturates at WINDOW when the last cycle overshoots (3+2)
        tbl.push_back(mk(1, 10,                    2'b11, 10,                    11, 'h100, 'h104, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0,  2));
        tbl.push_back(mk(0, 0,                     2'b01, 12,                    0,  'h108, 'h000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0,  3));
        tbl.push_back(mk(0, 0,                     2'b11, 13,                    14, 'h10C, 'h110, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0,  4));
        // pc break across cycles on ch0 (predecessor is the carried last pc)
        tbl.push_back(mk(1, 10,                    2'b01, 10,                    0,  'h100, 'h000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0,  1));
        tbl.push_back(mk(0, 0,                     2'b01, 11,                    0,  'h300, 'h000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 2, 0, 11, 1));

        // Reset state, then start -> busy one edge later.
        clear_inputs();
        #3;
        check_status("reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        resetn = 1'b1;
        do_start(10);
        check_status("start", 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.nw) begin
                do_reset();
                do_start(v.so);
            end
            apply(v);
            check_status($sformatf("vec%0d", i), !(v.e_done || v.e_fail), v.e_done, v.e_fail,
                         v.e_code, v.e_chan, v.e_ord, v.e_ret);
        end

        // Asynchronous reset mid-run, then a fresh run with no stale pc history.
        do_reset();
        do_start(10);
        apply(mk(0, 0, 2'b11, 10, 11, 'h100, 'h104, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2));
        check_status("midrun", 1, 0, 0, 0, 0, 0, 2);
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check_status("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        resetn = 1'b1;
        do_start(100);
        check_status("restart", 1, 0, 0, 0, 0, 0, 0);
        apply(mk(0, 0, 2'b11, 100, 101, 'h500, 'h504, 2'b00, 2'b00, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2));
        check_status("restart_run", 1, 0, 0, 0, 0, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
